// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package bit_serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fullAdder_1bit.sv
// Single 1-bit full-adder cell, time-shared across every bit position.
module fullAdder_1bit #(
    parameter int unsigned GATE_DELAY = 1
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // GATE_DELAY only annotated the legacy gate-level model; the logic is the same either way.
    if (GATE_DELAY == 0) begin : g_zero_delay
        assign sum  = a ^ b ^ cin;
        assign cout = (a & b) | (cin & (a ^ b));
    end else begin : g_annotated_delay
        assign sum  = a ^ b ^ cin;
        assign cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// WIDTH-bit add/subtract through one shared full-adder cell, LSB first, one bit per clock.
// Define BIT_SERIAL_FLAGS_EN to enable the overflow/zero/negative flags.
module bit_serial_alu_seq
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] result_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             carry_q;
    logic             cell_sum, cell_cout;
    logic             last_bit;

    assign last_bit   = (bit_cnt == LAST);
    assign result_nxt = {cell_sum, result[WIDTH-1:1]};

    fullAdder_1bit #(
        .GATE_DELAY(0)
    ) u_cell (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            bit_cnt <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= sub ? ~b : b;
                        carry_q <= sub;
                        bit_cnt <= '0;
                        result  <= '0;
                    end
                end
                RUN: begin
                    result  <= result_nxt;
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    carry_q <= cell_cout;
                    if (last_bit) carry   <= cell_cout;
                    else          bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIT_SERIAL_FLAGS_EN
    logic msb_cin, zero_q, negative_q;

    // carry-in of the MSB is still in carry_q on the last RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            msb_cin    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else if (state == RUN && last_bit) begin
            msb_cin    <= carry_q;
            zero_q     <= (result_nxt == '0);
            negative_q <= cell_sum;
        end
    end

    assign overflow = msb_cin ^ carry;
    assign zero     = zero_q;
    assign negative = negative_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq: 8-bit instance against a behavioural model, 64-bit directed.
module tb_bit_serial_alu_seq;

    localparam int unsigned W = 8;
`ifdef BIT_SERIAL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, sub;
    logic [W-1:0] a, b, result;
    logic         busy, done, carry, overflow, zero, negative;

    logic         start64, sub64;
    logic [63:0]  a64, b64, result64;
    logic         busy64, done64, carry64, ov64, zero64, neg64;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    bit_serial_alu_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .sub(sub64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(result64), .carry(carry64),
        .overflow(ov64), .zero(zero64), .negative(neg64)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: cycles since acceptance (0 = idle, W+1 = done cycle) and expected outcome.
    int           m_cnt = 0;
    int           m_ops = 0;
    logic [W-1:0] m_res = '0;
    logic         m_c = 1'b0, m_ov = 1'b0, m_z = 1'b0, m_n = 1'b0;

    function automatic void model_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int unsigned  xi = x;
        int unsigned  yi = y;
        logic [W-1:0] r;
        r     = s ? (x - y) : (x + y);
        m_res = r;
        m_c   = s ? (xi >= yi) : ((xi + yi) > ((1 << W) - 1));
        m_ov  = FLAGS_EN && (s ? (x[W-1] != y[W-1] && r[W-1] != x[W-1])
                               : (x[W-1] == y[W-1] && r[W-1] != x[W-1]));
        m_z   = FLAGS_EN && (r == '0);
        m_n   = FLAGS_EN && r[W-1];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0;
            m_res = '0;
            m_c = 1'b0; m_ov = 1'b0; m_z = 1'b0; m_n = 1'b0;
        end else if (m_cnt == W + 1) begin
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt++;
        end else if (start) begin
            m_cnt = 1;
            m_ops++;
            model_op(a, b, sub);
        end
    end

    bit checking = 1'b0;
    int dut_dones = 0;
    int m_dones = 0;

    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, m_cnt != 0);
            check("done", done, m_cnt == W + 1);
            if (done) dut_dones++;
            if (m_cnt == W + 1) m_dones++;
            if (m_cnt == 0 || m_cnt == W + 1) begin
                check("result", result, m_res);
                check("carry", carry, m_c);
                check("overflow", overflow, m_ov);
                check("zero", zero, m_z);
                check("negative", negative, m_n);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_cnt != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 1'b0);
    endtask

    // Issue one 8-bit operation, scramble operands during RUN, return on the done cycle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int lat = 0;
        wait_idle();
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 40) begin
            a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W);
    endtask

    task automatic lit8(input string tag, input logic [W-1:0] r, input logic c,
                        input logic ov, input logic z, input logic n);
        check({tag, "_res"}, result, r);
        check({tag, "_model"}, m_res, r);
        check({tag, "_carry"}, carry, c);
        check({tag, "_ovf"}, overflow, FLAGS_EN && ov);
        check({tag, "_zero"}, zero, FLAGS_EN && z);
        check({tag, "_neg"}, negative, FLAGS_EN && n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, o0, lat;
        logic [63:0] x64, y64, exp64;
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start64 = 1'b0; sub64 = 1'b0; a64 = '0; b64 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        check("rst_carry", carry, 1'b0);
        check("rst_busy64", busy64, 1'b0);
        reset = 1'b0;
        checking = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0); lit8("add_0f_01", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0); lit8("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op(8'h05, 8'h05, 1'b1); lit8("sub_05_05", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(8'h03, 8'h05, 1'b1); lit8("sub_03_05", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0); lit8("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b1); lit8("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom()), W'($urandom()), 1'($urandom()));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // start held high: accepted every W+2 cycles, done once per operation
        wait_idle();
        d0 = dut_dones; o0 = m_ops;
        start = 1'b1;
        for (int i = 0; i < 35; i++) begin
            a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        check("hold_model_ops", m_ops - o0, 4);
        check("hold_dut_dones", dut_dones - d0, 4);

        // reset during the 4th RUN cycle discards the operation
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, '0);
        check("midrst_flags", {carry, overflow, zero, negative}, 4'b0000);
        reset = 1'b0;
        run_op(8'h3C, 8'h42, 1'b0); lit8("after_rst", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // 64-bit instance: wrap-around boundary plus random operations
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                x64 = '1; y64 = 64'd1; sub64 = 1'b0;
            end else begin
                x64 = {$urandom(), $urandom()}; y64 = {$urandom(), $urandom()};
                sub64 = 1'($urandom());
            end
            exp64 = sub64 ? (x64 - y64) : (x64 + y64);
            a64 = x64; b64 = y64; start64 = 1'b1;
            @(negedge clk);
            start64 = 1'b0;
            lat = 0;
            while (!done64 && lat < 100) begin
                a64 = {$urandom(), $urandom()};
                @(negedge clk);
                lat++;
            end
            check("lat64", lat, 64);
            check("result64", result64, exp64);
            check("carry64", carry64, sub64 ? (x64 >= y64) : (exp64 < x64));
            check("zero64", zero64, FLAGS_EN && (exp64 == '0));
            check("neg64", neg64, FLAGS_EN && exp64[63]);
            if (i == 0) begin
                check("wrap64_res", result64, 64'd0);
                check("wrap64_carry", carry64, 1'b1);
                check("wrap64_ovf", ov64, 1'b0);
            end
            @(negedge clk);
            check("idle64", busy64, 1'b0);
        end

        wait_idle();
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
